// File: rtl/fpu_io_register_bank_if.sv
// rtl/fpu_io_register_bank_if.sv - chip-select data port between the CPU data bus mux and the FPU register bank
interface fpu_io_register_bank_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  cs;
    logic [ADDR_WIDTH-1:0] data_m_addr;
    logic [15:0]           data_m_data_in;
    logic [1:0]            data_m_bytesel;
    logic                  data_m_wr_en;
    logic                  data_m_ack;
    logic [15:0]           data_m_data_out;

    modport master (
        output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en,
        input  data_m_ack, data_m_data_out
    );

    modport slave (
        input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en,
        output data_m_ack, data_m_data_out
    );
endinterface

// File: rtl/fpu_io_register_bank.sv
// rtl/fpu_io_register_bank.sv - memory-mapped FPU I/O register bank with byte selects, W1C bits and hardware load/set
module fpu_io_register_bank #(
    parameter int                      NUM_REGS      = 4,
    parameter int                      ADDR_WIDTH    = 2,
    parameter logic [16*NUM_REGS-1:0]  RESET_VALUES  = {16'h0000, 16'hFFFF, 16'h0000, 16'h037F},
    parameter logic [16*NUM_REGS-1:0]  WRITABLE_MASK = {16'hFFFF, 16'hFFFF, 16'h0000, 16'h1F7F},
    parameter logic [16*NUM_REGS-1:0]  W1C_MASK      = {16'h0000, 16'h0000, 16'h00FF, 16'h0000}
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    fpu_io_register_bank_if.slave      bus,
    output logic [16*NUM_REGS-1:0]     o_reg_out,
    output logic [NUM_REGS-1:0]        o_reg_write,
    input  logic [NUM_REGS-1:0]        i_hw_load,
    input  logic [16*NUM_REGS-1:0]     i_hw_load_data,
    input  logic [16*NUM_REGS-1:0]     i_hw_set
);

    logic [15:0]         r_regs [NUM_REGS];
    logic                r_ack;
    logic [15:0]         r_data_out;
    logic [NUM_REGS-1:0] r_reg_write;

    logic [15:0]         w_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_sel;
    logic [15:0]         w_rd_data;
    logic [15:0]         w_be;
    logic                w_start;
    logic                w_commit;

    // A new transaction is only accepted in the cycle after ack drops, giving one ack per two cycles under a held cs
    assign w_start  = bus.cs & ~r_ack;
    assign w_be     = {{8{bus.data_m_bytesel[1]}}, {8{bus.data_m_bytesel[0]}}};
    // An empty byte select or an unmapped address still gets an ack but never commits
    assign w_commit = w_start & bus.data_m_wr_en & (|w_sel) & (|bus.data_m_bytesel);

    // Address decode: one-hot select plus read mux; unmapped addresses leave both at zero
    always_comb begin
        w_sel     = '0;
        w_rd_data = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.data_m_addr == ADDR_WIDTH'(i)) begin
                w_sel[i]  = 1'b1;
                w_rd_data = r_regs[i];
            end
        end
    end

    // Next value per register: hw_load beats software write beats hold, then hw_set is OR-ed on top
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_regs[i];
            if (i_hw_load[i]) begin
                w_next[i] = i_hw_load_data[16*i +: 16];
            end else if (w_commit && w_sel[i]) begin
                // W1C bits are excluded from the plain writable set so a W1C bit never takes din directly
                w_next[i] = (r_regs[i]
                             & ~(W1C_MASK[16*i +: 16] & w_be & bus.data_m_data_in)
                             & ~(WRITABLE_MASK[16*i +: 16] & ~W1C_MASK[16*i +: 16] & w_be))
                          | (bus.data_m_data_in & WRITABLE_MASK[16*i +: 16] & ~W1C_MASK[16*i +: 16] & w_be);
            end
            w_next[i] = w_next[i] | i_hw_set[16*i +: 16];
        end
    end

    // Register file, handshake and read-data flops; reset discards anything presented in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUES[16*i +: 16];
            end
            r_ack       <= 1'b0;
            r_data_out  <= 16'h0000;
            r_reg_write <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_next[i];
            end
            r_ack       <= w_start;
            r_reg_write <= w_commit ? w_sel : '0;
            if (w_start && !bus.data_m_wr_en) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    // Flatten the register flops onto the packed output bus
    always_comb begin
        o_reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_reg_out[16*i +: 16] = r_regs[i];
        end
    end

    assign bus.data_m_ack      = r_ack;
    assign bus.data_m_data_out = r_data_out;
    assign o_reg_write         = r_reg_write;

endmodule
